ysyx_axi4_sram: RTL and testbench

YSYX_AXI4_SRAM -- requirements
Module: ysyx_axi4_sram

---
 rtl/ysyx_axi4_sram.sv | 239 +++++++++++++++++++++++
 tb/tb_ysyx_axi4_sram.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_axi4_sram.sv
// AXI4 slave SRAM model: 2^DEPTH_W x 64-bit words, INCR bursts only,
// independent read and write channels, fixed read latency, byte strobes.
module ysyx_axi4_sram #(
  parameter int DEPTH_W = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [3:0]  rid,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int WORDS = 1 << DEPTH_W;
  localparam logic [DEPTH_W-1:0] IDX_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
  // Last value of the wait counter before data is presented (unused when LATENCY==1).
  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 2);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [63:0] mem [0:WORDS-1];

  r_state_e           r_state_q, r_state_d;
  logic [DEPTH_W-1:0] r_idx_q, r_idx_d, r_idx_inc, ar_idx;
  logic [7:0]         r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [3:0]         lat_cnt_q, lat_cnt_d;
  logic [3:0]         rid_q, rid_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d, rlast_q, rlast_d;

  w_state_e           w_state_q, w_state_d;
  logic [DEPTH_W-1:0] w_idx_q, w_idx_d, aw_idx;
  logic [7:0]         w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic               w_err_q, w_err_d, w_is_last, w_err_next, mem_we;
  logic [3:0]         bid_q, bid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               bvalid_q, bvalid_d;

  logic               unused_addr_bits;

  assign ar_idx    = araddr[DEPTH_W+2:3];
  assign aw_idx    = awaddr[DEPTH_W+2:3];
  assign r_idx_inc = r_idx_q + IDX_ONE;
  assign unused_addr_bits = ^{araddr[31:DEPTH_W+3], araddr[2:0],
                              awaddr[31:DEPTH_W+3], awaddr[2:0]};

  assign w_is_last  = (w_cnt_q == w_len_q);
  assign w_err_next = w_err_q | (wlast != w_is_last);
  assign mem_we     = (w_state_q == W_DATA) && wvalid && !rst;

  // Read channel next-state: address capture, latency wait, then one beat per R handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    lat_cnt_d = lat_cnt_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_idx_d   = ar_idx;
          rid_d     = arid;
          r_len_d   = arlen;
          r_cnt_d   = 8'd0;
          lat_cnt_d = 4'd0;
          if (LATENCY == 1) begin
            r_state_d = R_DATA;
            rvalid_d  = 1'b1;
            rlast_d   = (arlen == 8'd0);
            rdata_d   = mem[ar_idx];
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rlast_d   = (r_len_q == 8'd0);
          rdata_d   = mem[r_idx_q];
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_idx_d = r_idx_inc;
            r_cnt_d = r_cnt_q + 8'd1;
            rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
            rdata_d = mem[r_idx_inc];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write channel next-state: address capture, strobed beats, then B response.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_idx_d   = aw_idx;
          bid_d     = awid;
          w_len_d   = awlen;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          w_err_d = w_err_next;
          if (w_is_last) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = w_err_next ? 2'b10 : 2'b00;
          end else begin
            w_idx_d = w_idx_q + IDX_ONE;
            w_cnt_d = w_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // State and output registers for both channels; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      lat_cnt_q <= 4'd0;
      rid_q     <= 4'd0;
      rdata_q   <= 64'd0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
      bid_q     <= 4'd0;
      bresp_q   <= 2'b00;
      bvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Byte-strobed memory write; a same-edge read load still sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) begin
          mem[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign arready = (r_state_q == R_IDLE) && !rst;
  assign awready = (w_state_q == W_IDLE) && !rst;
  assign wready  = (w_state_q == W_DATA);
  assign rdata   = rdata_q;
  assign rid     = rid_q;
  assign rresp   = 2'b00;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_ysyx_axi4_sram.sv
// Self-checking bench for ysyx_axi4_sram: single-beat vector table plus
// burst, stall, wlast-error, wrap and mid-burst reset sequences.
module tb_ysyx_axi4_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  ysyx_axi4_sram #(.DEPTH_W(12), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [3:0]  id;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[5];
  int          errors = 0;
  int          checks = 0;

  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic        b_next;
  logic [63:0] got_data[16];
  logic        got_last[16];
  logic [3:0]  got_rid;
  logic [1:0]  got_rresp;
  int          got_beats;
  int          read_lat;
  int          read_cycles;
  int          stall_errs;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Full AW/W/B transaction; beat i carries base+i, wlast is driven on beat wlast_beat.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [63:0] base, input logic [7:0] strb, input int wlast_beat);
    int g;
    awaddr = addr; awid = id; awlen = len; awvalid = 1'b1;
    g = 0;
    while (!awready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) checkOutput("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = base + 64'(i); wstrb = strb; wlast = (i == wlast_beat);
      g = 0;
      while (!wready && g < 50) begin @(posedge clk); #1; g++; end
      if (g >= 50) checkOutput("w_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_next = bvalid;
    g = 0;
    while (!bvalid && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) checkOutput("b_timeout", 64'd0, 64'd1);
    b_resp = bresp; b_id = bid;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Full AR/R transaction; rready held high or toggled 1,0,1,0 from the first valid cycle.
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input bit toggle);
    int g;
    int k;
    bit stalled;
    logic [63:0] stall_data;
    araddr = addr; arid = id; arlen = len; arvalid = 1'b1;
    g = 0;
    while (!arready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) checkOutput("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    read_lat = 1;
    while (!rvalid && read_lat < 40) begin @(posedge clk); #1; read_lat++; end
    got_rid = rid;
    got_rresp = rresp;
    got_beats = 0; stall_errs = 0; stalled = 0; k = 0; read_cycles = 0; stall_data = 64'd0;
    while (got_beats <= int'(len) && read_cycles < 100) begin
      rready = toggle ? (k % 2 == 0) : 1'b1;
      k++;
      if (rvalid) begin
        if (stalled && rdata !== stall_data) stall_errs++;
        if (rready) begin
          got_data[got_beats] = rdata;
          got_last[got_beats] = rlast;
          got_beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          stall_data = rdata;
          if (rlast !== (got_beats == int'(len))) stall_errs++;
        end
      end
      @(posedge clk); #1;
      read_cycles++;
    end
    rready = 1'b0;
  endtask

  // One table entry: single-beat write followed by single-beat read back.
  task automatic applyStimulus(input int i);
    write_burst(vecs[i].waddr, vecs[i].id, 8'd0, vecs[i].wdata, vecs[i].strb, 0);
    checkOutput($sformatf("v%0d_bvalid_next", i), 64'(b_next), 64'd1);
    checkOutput($sformatf("v%0d_bresp", i), 64'(b_resp), 64'd0);
    checkOutput($sformatf("v%0d_bid", i), 64'(b_id), 64'(vecs[i].id));
    read_burst(vecs[i].raddr, vecs[i].id ^ 4'hF, 8'd0, 1'b0);
    checkOutput($sformatf("v%0d_latency", i), 64'(read_lat), 64'd2);
    checkOutput($sformatf("v%0d_rid", i), 64'(got_rid), 64'(vecs[i].id ^ 4'hF));
    checkOutput($sformatf("v%0d_rresp", i), 64'(got_rresp), 64'd0);
    checkOutput($sformatf("v%0d_rdata", i), got_data[0], vecs[i].exp);
    checkOutput($sformatf("v%0d_rlast", i), 64'(got_last[0]), 64'd1);
    checkOutput($sformatf("v%0d_beats", i), 64'(got_beats), 64'd1);
  endtask

  // Watchdog so a stuck handshake can never hang the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    vecs[0] = '{waddr: 32'h100,  raddr: 32'h100,  id: 4'h3, wdata: 64'h1122334455667788, strb: 8'hFF, exp: 64'h1122334455667788};
    vecs[1] = '{waddr: 32'h100,  raddr: 32'h100,  id: 4'h5, wdata: 64'hFFFFFFFF_AAAAAAAA, strb: 8'h0F, exp: 64'h11223344AAAAAAAA};
    vecs[2] = '{waddr: 32'h8107, raddr: 32'h100,  id: 4'h7, wdata: 64'hAB00000000000000, strb: 8'h80, exp: 64'hAB223344AAAAAAAA};
    vecs[3] = '{waddr: 32'h100,  raddr: 32'h8100, id: 4'h9, wdata: 64'h0,                strb: 8'h00, exp: 64'hAB223344AAAAAAAA};
    vecs[4] = '{waddr: 32'h7FF8, raddr: 32'h7FF8, id: 4'hC, wdata: 64'h0123456789ABCDEF, strb: 8'hFF, exp: 64'h0123456789ABCDEF};

    rst = 1'b1;
    araddr = '0; arid = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_awready", 64'(awready), 64'd0);
    checkOutput("rst_wready", 64'(wready), 64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
    checkOutput("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_arready", 64'(arready), 64'd1);
    checkOutput("rel_awready", 64'(awready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) applyStimulus(i);

    // awlen=1 with wlast on the first beat: both beats land, SLVERR reported
    write_burst(32'h300, 4'h2, 8'd1, 64'h50, 8'hFF, 0);
    checkOutput("early_wlast_bresp", 64'(b_resp), 64'd2);
    read_burst(32'h300, 4'h2, 8'd1, 1'b0);
    checkOutput("early_wlast_beat0", got_data[0], 64'h50);
    checkOutput("early_wlast_beat1", got_data[1], 64'h51);

    // wlast never asserted on the final beat
    write_burst(32'h310, 4'h4, 8'd0, 64'h77, 8'hFF, 5);
    checkOutput("missing_wlast_bresp", 64'(b_resp), 64'd2);

    // 4-beat burst then stalled read with rready toggling
    write_burst(32'h200, 4'h6, 8'd3, 64'd1, 8'hFF, 3);
    checkOutput("burst_bresp", 64'(b_resp), 64'd0);
    checkOutput("burst_bid", 64'(b_id), 64'd6);
    read_burst(32'h200, 4'hA, 8'd3, 1'b1);
    checkOutput("burst_beats", 64'(got_beats), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("burst_data%0d", i), got_data[i], 64'(i + 1));
      checkOutput($sformatf("burst_last%0d", i), 64'(got_last[i]), 64'(i == 3));
    end
    checkOutput("burst_stall_stable", 64'(stall_errs), 64'd0);
    checkOutput("burst_end_rvalid", 64'(rvalid), 64'd0);
    checkOutput("burst_end_arready", 64'(arready), 64'd1);

    // Burst crossing the top of memory wraps to word 0, read back-to-back
    write_burst(32'h7FF8, 4'h1, 8'd1, 64'h10, 8'hFF, 1);
    read_burst(32'h7FF8, 4'h1, 8'd1, 1'b0);
    checkOutput("wrap_beat0", got_data[0], 64'h10);
    checkOutput("wrap_beat1", got_data[1], 64'h11);
    checkOutput("wrap_cycles", 64'(read_cycles), 64'd2);
    read_burst(32'h0, 4'h1, 8'd0, 1'b0);
    checkOutput("wrap_word0", got_data[0], 64'h11);

    // Reset asserted while beat 2 of a 4-beat read is presented
    araddr = 32'h200; arid = 4'hB; arlen = 8'd3; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    begin
      int g;
      g = 0;
      while (!rvalid && g < 40) begin @(posedge clk); #1; g++; end
      if (g >= 40) checkOutput("rstmid_rvalid_timeout", 64'd0, 64'd1);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rready = 1'b0;
    checkOutput("rstmid_beat2", rdata, 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmid_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rstmid_rdata", rdata, 64'd0);
    checkOutput("rstmid_rid", 64'(rid), 64'd0);
    checkOutput("rstmid_arready", 64'(arready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstmid_rel_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    checkOutput("rstmid_no_resp", 64'(rvalid), 64'd0);
    read_burst(32'h200, 4'h3, 8'd0, 1'b0);
    checkOutput("rstmid_mem_kept", got_data[0], 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
